// File: rtl/lcd_video_rx.sv
// RGB565 parallel-LCD receiver: timing recovery, mode check, lock FSM and line-buffer write port.
// Build option: define LCD_VIDEO_RX_EXPAND_EN to widen channels by MSB replication instead of zero padding.
module lcd_video_rx #(
    parameter int H_ACTIVE      = 800,
    parameter int V_ACTIVE      = 480,
    parameter int H_TOTAL       = 928,
    parameter int LOCK_FRAMES   = 2,
    parameter int TIMEOUT_LINES = 4
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    input  logic        vid_de,
    input  logic [4:0]  vid_r,
    input  logic [5:0]  vid_g,
    input  logic [4:0]  vid_b,
    output logic [9:0]  wr_addr,
    output logic [23:0] wr_data,
    output logic        wr_en,
    output logic        line_done,
    output logic [9:0]  line_num,
    output logic        frame_start,
    output logic        locked,
    output logic        err_pulse,
    output logic [7:0]  err_count,
    output logic [11:0] meas_h_total
);

    localparam int TO_CLKS = TIMEOUT_LINES * H_TOTAL;
    localparam int TO_W    = $clog2(TO_CLKS + 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    logic       r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
    logic [4:0] r_r1, r_b1, r_r2, r_b2;
    logic [5:0] r_g1, r_g2;

    logic [9:0]      r_pix_cnt, r_line_cnt;
    logic            r_line_done, r_frame_start;
    logic [11:0]     r_per, r_meas;
    logic [TO_W-1:0] r_to;
    logic            r_skip_hs, r_frame_bad, r_seen_vs;

    state_t     r_state, w_state_nx;
    logic [3:0] r_good_cnt, w_good_nx;
    logic       r_err_pulse, w_err_nx;
    logic [7:0] r_err_cnt, w_errcnt_nx;

    logic       w_hs_rise, w_vs_rise, w_de_rise, w_de_fall;
    logic       w_line_bad, w_per_bad, w_frame_good, w_timeout;
    logic [9:0] w_lines_now;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            {r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2} <= '0;
            r_r1 <= '0; r_g1 <= '0; r_b1 <= '0;
            r_r2 <= '0; r_g2 <= '0; r_b2 <= '0;
        end else begin
            r_hs1 <= vid_hsync; r_vs1 <= vid_vsync; r_de1 <= vid_de;
            r_r1  <= vid_r;     r_g1  <= vid_g;     r_b1  <= vid_b;
            r_hs2 <= r_hs1;     r_vs2 <= r_vs1;     r_de2 <= r_de1;
            r_r2  <= r_r1;      r_g2  <= r_g1;      r_b2  <= r_b1;
        end
    end

    assign w_hs_rise = r_hs1 & ~r_hs2;
    assign w_vs_rise = r_vs1 & ~r_vs2;
    assign w_de_rise = r_de1 & ~r_de2;
    assign w_de_fall = ~r_de1 & r_de2;

    // Line and frame bookkeeping resolve one cycle after their edges, so a DE fall
    // coinciding with a VSYNC rise is folded into the closing frame's verdict.
    assign w_line_bad   = r_line_done && (r_pix_cnt != 10'(H_ACTIVE));
    assign w_lines_now  = (r_line_done && r_line_cnt != 10'h3FF) ? r_line_cnt + 10'd1 : r_line_cnt;
    assign w_per_bad    = w_hs_rise && !r_skip_hs && !w_vs_rise && (r_per != 12'(H_TOTAL));
    assign w_frame_good = !r_frame_bad && !w_line_bad && !w_per_bad &&
                          (w_lines_now == 10'(V_ACTIVE)) && r_seen_vs;
    assign w_timeout    = (r_to == TO_W'(TO_CLKS - 1)) && !w_hs_rise;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt   <= '0;
            r_line_done <= 1'b0;
        end else begin
            if (w_de_rise)
                r_pix_cnt <= '0;
            else if (r_de2 && r_pix_cnt != 10'h3FF)
                r_pix_cnt <= r_pix_cnt + 10'd1;
            r_line_done <= w_de_fall;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_per  <= '0;
            r_meas <= '0;
            r_to   <= '0;
        end else if (w_hs_rise) begin
            r_meas <= r_per;
            r_per  <= 12'd1;
            r_to   <= '0;
        end else begin
            if (r_per != 12'hFFF)
                r_per <= r_per + 12'd1;
            if (r_to != TO_W'(TO_CLKS - 1))
                r_to <= r_to + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_frame_bad   <= 1'b0;
            r_line_cnt    <= '0;
            r_skip_hs     <= 1'b1;
            r_seen_vs     <= 1'b0;
        end else begin
            r_frame_start <= w_vs_rise;
            if (w_vs_rise)
                r_skip_hs <= 1'b1;
            else if (w_hs_rise)
                r_skip_hs <= 1'b0;
            if (r_frame_start) begin
                r_frame_bad <= 1'b0;
                r_line_cnt  <= '0;
            end else begin
                if (w_line_bad || w_per_bad)
                    r_frame_bad <= 1'b1;
                if (r_line_done)
                    r_line_cnt <= w_lines_now;
            end
            if (w_timeout)
                r_seen_vs <= 1'b0;
            else if (r_frame_start)
                r_seen_vs <= 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SEARCH;
            r_good_cnt  <= '0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_good_cnt  <= w_good_nx;
            r_err_pulse <= w_err_nx;
            r_err_cnt   <= w_errcnt_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_good_nx   = r_good_cnt;
        w_err_nx    = 1'b0;
        w_errcnt_nx = r_err_cnt;
        if (r_frame_start) begin
            case (r_state)
                SEARCH: begin
                    w_state_nx = MEASURE;
                    w_good_nx  = '0;
                end
                MEASURE: begin
                    if (w_frame_good) begin
                        w_good_nx = r_good_cnt + 4'd1;
                        if (r_good_cnt + 4'd1 >= 4'(LOCK_FRAMES))
                            w_state_nx = LOCKED;
                    end else begin
                        w_good_nx = '0;
                    end
                end
                LOCKED: begin
                    if (!w_frame_good) begin
                        w_state_nx = MEASURE;
                        w_good_nx  = '0;
                        w_err_nx   = 1'b1;
                        if (r_err_cnt != 8'hFF)
                            w_errcnt_nx = r_err_cnt + 8'd1;
                    end
                end
                default: w_state_nx = SEARCH;
            endcase
        end
        // Loss of HSYNC overrides any frame verdict.
        if (w_timeout) begin
            w_state_nx = SEARCH;
            w_good_nx  = '0;
        end
    end

`ifdef LCD_VIDEO_RX_EXPAND_EN
    assign wr_data = {r_r2, r_r2[4:2], r_g2, r_g2[5:4], r_b2, r_b2[4:2]};
`else
    assign wr_data = {r_r2, 3'b000, r_g2, 2'b00, r_b2, 3'b000};
`endif

    assign locked       = (r_state == LOCKED);
    assign wr_en        = r_de2 && locked && (r_pix_cnt < 10'(H_ACTIVE));
    assign wr_addr      = r_pix_cnt;
    assign line_done    = r_line_done;
    assign line_num     = r_line_cnt;
    assign frame_start  = r_frame_start;
    assign err_pulse    = r_err_pulse;
    assign err_count    = r_err_cnt;
    assign meas_h_total = r_meas;

endmodule

// File: doc/lcd_video_rx.md
Name: lcd_video_rx

Overview:
- Receiver for the parallel RGB565 LCD timing protocol: active-high HSYNC/VSYNC, active-high DE, 5/6/5 colour bus, all sampled on clk_pixel.
- Recovers pixel and line coordinates, checks timing against the configured mode, and declares lock after consecutive good frames.
- When locked, streams captured pixels as 24-bit words into a line-buffer write port. Used for loopback test of the panel output and for external video capture.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_TOTAL, 928, expected clocks per line (HSYNC rise to HSYNC rise)
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- TIMEOUT_LINES, 4, loss timeout in units of H_TOTAL clocks without an HSYNC rise

Ports:
- clk_pixel  in  1  pixel clock; all logic in this single domain
- rst_n  in  1  asynchronous, active-low reset
- vid_hsync  in  1  horizontal sync, active high
- vid_vsync  in  1  vertical sync, active high
- vid_de  in  1  data enable, active high
- vid_r  in  5  red
- vid_g  in  6  green
- vid_b  in  5  blue
- wr_addr  out  10  pixel index within the current line
- wr_data  out  24  pixel as {R8,G8,B8}
- wr_en  out  1  write strobe
- line_done  out  1  1-cycle pulse at the end of each active line
- line_num  out  10  index of the line just completed; valid with line_done
- frame_start  out  1  1-cycle pulse on each VSYNC rising edge
- locked  out  1  high in LOCKED state
- err_pulse  out  1  1-cycle pulse when a frame fails checks while LOCKED
- err_count  out  8  saturating count of err_pulse events
- meas_h_total  out  12  last measured HSYNC period in clocks

Behaviour:
- Reset: every output is 0; FSM enters SEARCH; all counters are cleared.
- Input stage: all vid_* inputs are registered once (stage 1). Edges are detected between stage 1 and a stage-2 copy. A pixel present on vid_* at cycle n appears on wr_data/wr_en at cycle n+2 (fixed latency of 2).
- Pixel counter:
  - Cleared on the DE rising edge; increments on each DE-high stage-2 cycle.
  - Saturates at 1023.
  - wr_addr equals the counter value for the pixel being written.
- wr_en = stage-2 DE AND locked AND pixel counter < H_ACTIVE. Pixels beyond H_ACTIVE are never written.
- DE falling edge:
  - line_done pulses the following cycle; line_num is the active-line count.
  - The line is bad if the pixel count is not equal to H_ACTIVE.
  - The active-line count then increments, saturating at 1023.
- HSYNC rising edge:
  - The period counter value is latched into meas_h_total (counter saturates at 4095), then the counter clears.
  - A mismatch with H_TOTAL marks the frame bad.
  - The first HSYNC after a VSYNC rise is excluded from the check.
- VSYNC rising edge:
  - frame_start pulses.
  - The frame is good if no line or period errors occurred, the active-line count equals V_ACTIVE, and a full frame was observed since the previous VSYNC rise.
  - Then the line count and bad flag clear.
- FSM:
  - SEARCH: on a VSYNC rise, go to MEASURE with good_cnt=0. The first partial frame is never judged.
  - MEASURE: on a VSYNC rise, a good frame increments good_cnt; at LOCK_FRAMES, go to LOCKED. A bad frame sets good_cnt=0.
  - LOCKED: on a bad frame, pulse err_pulse, increment err_count (saturating at 255), set good_cnt=0, and go to MEASURE. locked drops on the same cycle as err_pulse.
  - Any state: no HSYNC rise for TIMEOUT_LINES*H_TOTAL clocks sends the FSM to SEARCH. locked=0 and wr_en is suppressed immediately.
- Simultaneous DE fall and VSYNC rise: the line is counted into the closing frame before the frame check.
- Reset mid-line: capture aborts; the partial frame after reset is discarded via SEARCH.

Optional Feature:
- Macro: LCD_VIDEO_RX_EXPAND_EN.
- Defined: channels are widened by MSB replication: R8={r,r[4:2]}, G8={g,g[5:4]}, B8={b,b[4:2]}. Full scale maps to 0xFF.
- Undefined: channels are zero-padded: R8={r,3'b0}, G8={g,2'b0}, B8={b,3'b0}.
- Latency is identical in both builds.

Test Plan:
- Three ideal 800x480 frames (H_TOTAL 928), pixel value = column index → locked rises on the 3rd VSYNC rise. In the following frame, wr_en asserts exactly 800 times per line, wr_addr runs 0..799, wr_data lags input by 2 cycles.
- While locked, one line with DE held 801 clocks → wr_en for addresses 0..799 only. err_pulse at the next VSYNC rise, err_count=1, locked=0. Relock after 2 further good frames.
- While locked, stop HSYNC/VSYNC for 4*928 clocks → locked=0 at that cycle; state SEARCH; a subsequent frame is not judged.
- One line with HSYNC period 930 → meas_h_total=930 and the frame is rejected; a 928-period line restores meas_h_total=928.
- Input r=5'h1F, g=6'h3F, b=0 → wr_data 0xFFFF00 with the macro defined, 0xF8FC00 without.
- Force 260 bad frames while cycling lock → err_count saturates at 255.
